// File: rtl/countdown_arbiter.sv
// Round-robin owner of one shared loadable down counter.
// A winner is picked and its start value is loaded into the counter. The counter
// enable is gated by a prescaler until the count reaches zero. The owner then
// gets a one-cycle done pulse.
module countdown_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_value,
  input  logic                    pause,
  input  logic [WIDTH-1:0]        cnt_count,
  output logic                    cnt_load,
  output logic [WIDTH-1:0]        cnt_value,
  output logic                    cnt_enable,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [NREQ-1:0]         done
);

  localparam int OW = $clog2(NREQ);
  localparam int SW = OW + 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_owner_q, last_owner_d;
  logic [WIDTH-1:0] cnt_value_q, cnt_value_d;
  logic [PW-1:0]    prescaler_q, prescaler_d;

  // Candidates in rotation order: slot 0 is the requester right after the last owner.
  logic [NREQ*OW-1:0] cand_idx_flat;
  logic [NREQ-1:0]    cand_req;
  logic               pick_found;
  logic [OW-1:0]      pick_idx;
  logic [NREQ-1:0]    owner_onehot;
  logic               owner_req;
  logic               tick;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum = SW'(last_owner_q) + SW'(gi + 1);
    assign cand_idx_flat[gi*OW +: OW] = (sum >= SW'(NREQ)) ? OW'(sum - SW'(NREQ)) : OW'(sum);
    assign cand_req[gi] = req[cand_idx_flat[gi*OW +: OW]];
  end

  assign owner_onehot = NREQ'(1) << owner_q;
  assign owner_req    = req[owner_q];
  assign tick         = (prescaler_q == PW'(DIV - 1));
  assign owner        = owner_q;
  assign cnt_value    = cnt_value_q;

  // Pick the earliest requesting candidate in rotation order.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx_flat[k*OW +: OW];
      end
    end
  end

  // Next-state logic and the outputs decoded from the current state.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_value_d  = cnt_value_q;
    prescaler_d  = prescaler_q;
    cnt_load     = 1'b0;
    cnt_enable   = 1'b0;
    grant        = '0;
    done         = '0;
    busy         = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (pick_found) begin
          owner_d     = pick_idx;
          cnt_value_d = req_value[pick_idx*WIDTH +: WIDTH];
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        grant       = owner_onehot;
        cnt_load    = 1'b1;
        prescaler_d = '0;
        if (!owner_req) begin
          // An abandoned grant still counts as a turn, so the rotation moves on.
          last_owner_d = owner_q;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        grant = owner_onehot;
        if (!owner_req) begin
          last_owner_d = owner_q;
          state_d      = S_IDLE;
        end else begin
          // Stop the enable at zero so the counter never wraps to all-ones.
          cnt_enable = tick && !pause && (cnt_count != '0);
          if (!pause) begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
          end
          if (cnt_count == '0) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        grant        = owner_onehot;
        done         = owner_onehot;
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      cnt_value_q  <= '0;
      prescaler_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_value_q  <= cnt_value_d;
      prescaler_q  <= prescaler_d;
    end
  end

endmodule

// File: tb/tb_countdown_arbiter.sv
// Bench for countdown_arbiter. It has two instances, with DIV=1 and DIV=3, and
// each instance drives its own model of the external down counter.
module tb_countdown_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int OW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_value;
  logic                  pause;
  logic                  sel;

  logic [WIDTH-1:0] cnt_a = '0;
  logic [WIDTH-1:0] cnt_b = '0;
  logic             load_a, load_b, en_a, en_b, busy_a, busy_b;
  logic [WIDTH-1:0] val_a, val_b;
  logic [NREQ-1:0]  grant_a, grant_b, done_a, done_b;
  logic [OW-1:0]    owner_a, owner_b;

  countdown_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .req(req), .req_value(req_value), .pause(pause),
    .cnt_count(cnt_a), .cnt_load(load_a), .cnt_value(val_a), .cnt_enable(en_a),
    .grant(grant_a), .owner(owner_a), .busy(busy_a), .done(done_a)
  );

  countdown_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIV(3)) dut_b (
    .clk(clk), .reset(reset), .req(req), .req_value(req_value), .pause(pause),
    .cnt_count(cnt_b), .cnt_load(load_b), .cnt_value(val_b), .cnt_enable(en_b),
    .grant(grant_b), .owner(owner_b), .busy(busy_b), .done(done_b)
  );

  // External counters: load wins, otherwise decrement on enable.
  always @(posedge clk) begin
    if (load_a) cnt_a <= val_a;
    else if (en_a) cnt_a <= cnt_a - 1'b1;
    if (load_b) cnt_b <= val_b;
    else if (en_b) cnt_b <= cnt_b - 1'b1;
  end

  logic [NREQ-1:0]  s_grant, s_done;
  logic [OW-1:0]    s_owner;
  logic [WIDTH-1:0] s_value, s_count;
  logic             s_load, s_enable, s_busy;
  assign s_grant  = sel ? grant_b : grant_a;
  assign s_done   = sel ? done_b  : done_a;
  assign s_owner  = sel ? owner_b : owner_a;
  assign s_value  = sel ? val_b   : val_a;
  assign s_count  = sel ? cnt_b   : cnt_a;
  assign s_load   = sel ? load_b  : load_a;
  assign s_enable = sel ? en_b    : en_a;
  assign s_busy   = sel ? busy_b  : busy_a;

  int vectors     = 0;
  int miscompares = 0;
  int last_model  = NREQ - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Lowest requesting index above the last owner, else the lowest requesting index overall.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
    int best_after, best_any;
    best_after = -1;
    best_any   = -1;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        best_any = i;
        if (i > last) best_after = i;
      end
    end
    return (best_after >= 0) ? best_after : best_any;
  endfunction

  function automatic bit in_win(input int rel, input int ps, input int pl);
    return (rel >= ps) && (rel < ps + pl);
  endfunction

  // One transaction starting in an idle cycle with req already applied.
  // The pause window [ps, ps+pl) and abort_k are cycle numbers relative to the first grant cycle.
  // "progress" counts unpaused run cycles. The count is therefore V - progress/DIV,
  // and the enable fires when progress mod DIV is DIV-1.
  task automatic txn(input int ps, input int pl, input int abort_k,
                     input logic [NREQ-1:0] extra, input bit jitter,
                     output int done_rel, output int pulses);
    int own, v, div, progress, k;
    bit finished, aborted;
    logic [NREQ-1:0] oh;
    logic exp_en;
    div      = sel ? 3 : 1;
    done_rel = -1;
    pulses   = 0;
    own      = model_pick(req, last_model);
    pause    = in_win(-1, ps, pl);
    @(negedge clk);
    chk("arb_busy", s_busy, 0);
    chk("arb_grant", s_grant, 0);
    chk("arb_done", s_done, 0);
    if (own < 0) begin
      vectors++;
      miscompares++;
      $error("FAIL txn_setup: observed req %0h required nonzero", req);
      return;
    end
    v  = int'(req_value[own*WIDTH +: WIDTH]);
    oh = '0;
    oh[own] = 1'b1;
    next_cycle();
    pause = in_win(0, ps, pl);
    req   = req | extra;
    @(negedge clk);
    chk("load_strobe", s_load, 1);
    chk("load_grant", s_grant, oh);
    chk("load_owner", s_owner, own);
    chk("load_value", s_value, v);
    chk("load_busy", s_busy, 1);
    chk("load_enable", s_enable, 0);
    chk("load_done", s_done, 0);
    next_cycle();
    progress = 0;
    finished = 0;
    aborted  = 0;
    for (k = 1; k <= 200 && !finished && !aborted; k++) begin
      pause = in_win(k, ps, pl);
      if (jitter) req = (NREQ'($urandom) & ~oh) | oh | extra;
      if (k == abort_k) req[own] = 1'b0;
      @(negedge clk);
      chk("run_grant", s_grant, oh);
      chk("run_done", s_done, 0);
      chk("run_load", s_load, 0);
      chk("run_count", s_count, v - progress / div);
      if (k == abort_k) begin
        chk("abort_enable", s_enable, 0);
        aborted = 1;
      end else begin
        exp_en = !pause && (progress < v * div) && ((progress % div) == div - 1);
        chk("run_enable", s_enable, exp_en);
        if (s_enable) pulses++;
        if (progress >= v * div) finished = 1;
        else if (!pause) progress++;
      end
      next_cycle();
    end
    if (aborted) begin
      last_model = own;
      pause = 1'b0;
      return;
    end
    if (!finished) begin
      vectors++;
      miscompares++;
      $error("FAIL run_timeout: observed no zero count after %0d cycles, required count %0d to reach 0", k, v);
      return;
    end
    pause = in_win(k, ps, pl);
    @(negedge clk);
    chk("done_pulse", s_done, oh);
    chk("done_grant", s_grant, oh);
    chk("done_busy", s_busy, 1);
    chk("done_enable", s_enable, 0);
    chk("done_count", s_count, 0);
    done_rel   = k;
    last_model = own;
    next_cycle();
    pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", s_busy, 0);
      chk("idle_grant", s_grant, 0);
      chk("idle_enable", s_enable, 0);
      next_cycle();
    end
  endtask

  task automatic random_txns(input int n);
    int dr, np, own, v, div, ps, pl, ab;
    for (int t = 0; t < n; t++) begin
      req = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) req_value[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      own = model_pick(req, last_model);
      v   = int'(req_value[own*WIDTH +: WIDTH]);
      div = sel ? 3 : 1;
      ps  = int'($urandom_range(0, v * div + 2));
      pl  = int'($urandom_range(0, 3));
      ab  = -1;
      if (v > 0 && $urandom_range(0, 4) == 0) ab = int'($urandom_range(1, v * div));
      txn(ps, pl, ab, '0, 1'b1, dr, np);
      if (ab < 0) chk("rand_pulses", np, v);
      if ($urandom_range(0, 2) == 0) begin
        req = '0;
        idle(1);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before 1 ms");
    $fatal(1);
  end

  initial begin
    int dr, np;
    int vals3 [4];
    reset = 1'b1;
    req = '0;
    req_value = '0;
    pause = 1'b0;
    sel = 1'b0;
    #2 reset = 1'b0;

    // 1: reset low for three cycles, then release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_busy", s_busy, 0);
    chk("rst_hold_grant", s_grant, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_grant", s_grant, 0);
    chk("rst_done", s_done, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_load", s_load, 0);
    chk("rst_enable", s_enable, 0);
    chk("rst_value", s_value, 0);
    chk("rst_owner", s_owner, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_owner_b", owner_b, 0);
    next_cycle();

    // 3: all four requesting, values 3,1,0,2 -> order 0,1,2,3,0
    vals3 = '{3, 1, 0, 2};
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_value[i*WIDTH +: WIDTH] = WIDTH'(vals3[i]);
    for (int i = 0; i < 5; i++) begin
      txn(-10, 0, -1, '0, 1'b0, dr, np);
      chk("t3_latency", dr, 2 + vals3[i % 4]);
    end
    req = '0;
    idle(2);

    // 2: single request, value 5
    req = 4'b0001;
    req_value = '0;
    req_value[3:0] = 4'd5;
    txn(-10, 0, -1, '0, 1'b0, dr, np);
    chk("t2_latency", dr, 7);
    chk("t2_pulses", np, 5);
    req = '0;
    idle(1);

    // 4: value 4 with a three-cycle pause mid-run
    req = 4'b0001;
    req_value[3:0] = 4'd4;
    txn(2, 3, -1, '0, 1'b0, dr, np);
    chk("t4_latency", dr, 9);
    chk("t4_pulses", np, 4);
    req = '0;
    idle(1);

    // 5: value 9, req0 dropped after count 6, req1 pending -> req1 wins next
    req = 4'b0001;
    req_value[3:0] = 4'd9;
    req_value[7:4] = 4'd2;
    txn(-10, 0, 5, 4'b0010, 1'b0, dr, np);
    chk("t5_req_after_abort", req, 4'b0010);
    txn(-10, 0, -1, '0, 1'b0, dr, np);
    chk("t5_next_latency", dr, 4);
    req = '0;
    idle(1);

    random_txns(25);
    req = '0;
    idle(1);

    // 6: switch to the DIV=3 instance from a clean reset
    reset = 1'b0;
    last_model = NREQ - 1;
    next_cycle();
    reset = 1'b1;
    sel = 1'b1;
    idle(1);
    req = 4'b0001;
    req_value = '0;
    req_value[3:0] = 4'd2;
    txn(-10, 0, -1, '0, 1'b0, dr, np);
    chk("t6_latency", dr, 8);
    chk("t6_pulses", np, 2);
    req = '0;
    idle(1);

    random_txns(8);
    req = '0;
    idle(1);

    // 6: asynchronous reset while an enable is active
    req = 4'b0001;
    req_value[3:0] = 4'd5;
    repeat (4) next_cycle();
    #2;
    chk("t6_pre_enable", s_enable, 1);
    reset = 1'b0;
    #1;
    chk("t6_async_grant", s_grant, 0);
    chk("t6_async_busy", s_busy, 0);
    chk("t6_async_enable", s_enable, 0);
    chk("t6_async_load", s_load, 0);
    last_model = NREQ - 1;
    req = '0;
    next_cycle();
    reset = 1'b1;
    idle(2);
    req = 4'b0001;
    req_value[3:0] = 4'd1;
    txn(-10, 0, -1, '0, 1'b0, dr, np);
    chk("t6_reload_latency", dr, 5);
    req = '0;
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
